// File: rtl/onehot_decoder_stream.sv
// Registered N-to-2^N binary-to-one-hot decoder behind a 2-entry code FIFO,
// with valid/ready on both sides and a sticky mask of delivered lines.
module onehot_decoder_stream #(
    parameter int N = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [(1<<N)-1:0]  out,
    input  logic               clr_seen,
    output logic [(1<<N)-1:0]  seen
);
    localparam int W = 1 << N;

    logic [N-1:0] head_p0;
    logic [N-1:0] tail_p0;
    logic [1:0]   count_p0;
    logic [W-1:0] seen_p0;
    logic         push;
    logic         pop;

    function automatic logic [W-1:0] decode(input logic [N-1:0] code);
        logic [W-1:0] line;
        line       = '0;
        line[code] = 1'b1;
        return line;
    endfunction

    // Handshake flags depend only on the registered occupancy.
    assign in_ready  = (count_p0 != 2'd2);
    assign out_valid = (count_p0 != 2'd0);
    assign out       = out_valid ? decode(head_p0) : '0;
    assign seen      = seen_p0;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_p0  <= '0;
            tail_p0  <= '0;
            count_p0 <= 2'd0;
            seen_p0  <= '0;
        end else begin
            if (push && pop) begin
                // Only reachable at count 1: the new code replaces the head.
                head_p0 <= in;
            end else if (pop) begin
                head_p0  <= tail_p0;
                count_p0 <= count_p0 - 2'd1;
            end else if (push) begin
                if (count_p0 == 2'd0) begin
                    head_p0 <= in;
                end else begin
                    tail_p0 <= in;
                end
                count_p0 <= count_p0 + 2'd1;
            end

            if (clr_seen) begin
                seen_p0 <= pop ? out : '0;
            end else if (pop) begin
                seen_p0 <= seen_p0 | out;
            end
        end
    end
endmodule

// File: tb/tb_onehot_decoder_stream.sv
// Directed and randomized check of onehot_decoder_stream against a queue model.
module tb_onehot_decoder_stream;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic       clr_seen;
    logic [7:0] seen;

    int errors = 0;
    int checks = 0;
    int q[$];
    logic [7:0] seen_m;

    onehot_decoder_stream #(.N(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in(in), .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .clr_seen(clr_seen), .seen(seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_out();
        if (q.size() == 0) return 8'h00;
        return 8'(1 << q[0]);
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".in_ready"},  in_ready,  (q.size() < 2));
        chk({tag, ".out_valid"}, out_valid, (q.size() > 0));
        chk({tag, ".out"},       out,       exp_out());
        chk({tag, ".seen"},      seen,      seen_m);
    endtask

    // One clock edge: predict the transfers from the model, then compare after the edge.
    task automatic step(input string tag);
        bit         p;
        bit         po;
        logic [7:0] o;
        int         code;
        p    = in_valid && (q.size() < 2);
        po   = out_ready && (q.size() > 0);
        o    = exp_out();
        code = int'(in);
        @(posedge clk);
        #1;
        if (po) void'(q.pop_front());
        if (p) q.push_back(code);
        if (clr_seen) seen_m = po ? o : 8'h00;
        else if (po) seen_m = seen_m | o;
        check_model(tag);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in = 3'd0; out_ready = 1'b0; clr_seen = 1'b0;
        seen_m = 8'h00;

        // Test 1: asynchronous reset with no clock edge
        #3 reset = 1'b1;
        #1;
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.out", out, 8'h00);
        chk("rst.seen", seen, 8'h00);
        #8 reset = 1'b0;

        // Test 2: single transfer
        in_valid = 1'b1; in = 3'd4; out_ready = 1'b1;
        step("single.push");
        chk("single.out", out, 8'h10);
        in_valid = 1'b0;
        step("single.pop");
        chk("single.seen", seen, 8'h10);

        // Test 3: streaming with no bubbles
        seen_m = 8'h00;
        clr_seen = 1'b1; step("clr"); clr_seen = 1'b0;
        in_valid = 1'b1;
        in = 3'd0; step("stream0"); chk("stream.out0", out, 8'h01);
        in = 3'd7; step("stream1"); chk("stream.out1", out, 8'h80);
        in = 3'd2; step("stream2"); chk("stream.out2", out, 8'h04);
        in = 3'd1; step("stream3"); chk("stream.out3", out, 8'h02);
        in_valid = 1'b0; step("stream4");
        chk("stream.seen", seen, 8'h87);

        // Test 4: full buffer then drain
        out_ready = 1'b0; in_valid = 1'b1;
        in = 3'd5; step("full.p5");
        in = 3'd6; step("full.p6");
        chk("full.in_ready", in_ready, 1'b0);
        in = 3'd3; step("full.hold");
        chk("full.out_hold", out, 8'h20);
        out_ready = 1'b1; step("drain0");
        chk("drain.out1", out, 8'h40);
        step("drain1");
        chk("drain.out2", out, 8'h08);
        in_valid = 1'b0; step("drain2");
        chk("drain.empty", out_valid, 1'b0);

        // Test 5: clear coincident with a transfer
        clr_seen = 1'b1; out_ready = 1'b0; step("clr2"); clr_seen = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int c = 4; c < 8; c++) begin
            in = 3'(c); step("fill");
        end
        in = 3'd1; step("fill1");
        in_valid = 1'b0; out_ready = 1'b0;
        chk("clrx.seen_pre", seen, 8'hF0);
        chk("clrx.out_pre", out, 8'h02);
        clr_seen = 1'b1; out_ready = 1'b1; step("clrx");
        clr_seen = 1'b0;
        chk("clrx.seen", seen, 8'h02);

        // Test 6: reset while holding two codes
        out_ready = 1'b0; in_valid = 1'b1;
        in = 3'd1; step("mid.p1");
        in = 3'd2; step("mid.p2");
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        q.delete(); seen_m = 8'h00;
        chk("mid.out_valid", out_valid, 1'b0);
        chk("mid.in_ready", in_ready, 1'b1);
        #1 reset = 1'b0;
        in_valid = 1'b1; in = 3'd3; out_ready = 1'b1;
        step("mid.p3");
        chk("mid.out", out, 8'h08);
        in_valid = 1'b0; step("mid.pop");

        // Randomized traffic, holding the input stable while it is stalled
        for (int i = 0; i < 400; i++) begin
            if (!(in_valid && q.size() >= 2)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in = 3'($urandom_range(0, 7));
            end
            out_ready = ($urandom_range(0, 2) != 0);
            clr_seen = ($urandom_range(0, 15) == 0);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
